// File: rtl/i2c_regmap_pkg.sv
// Shared constants for the I2C register map: widths, register addresses, bit positions.
package i2c_regmap_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned NUM_GP = 4;
  localparam int unsigned STS_W  = 2;

  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 8'h00;
  localparam logic [ADDR_W-1:0] ADDR_ID      = 8'h01;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 8'h02;
  localparam logic [ADDR_W-1:0] ADDR_EVT_CNT = 8'h03;
  localparam logic [ADDR_W-1:0] ADDR_GP0     = 8'h04;
  localparam logic [ADDR_W-1:0] ADDR_GP1     = 8'h05;
  localparam logic [ADDR_W-1:0] ADDR_GP2     = 8'h06;
  localparam logic [ADDR_W-1:0] ADDR_GP3     = 8'h07;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_EVT_MSK = 1;
  localparam int unsigned CTRL_OVF_MSK = 2;
  localparam int unsigned STS_EVT      = 0;
  localparam int unsigned STS_OVF      = 1;

  localparam logic [DATA_W-1:0] CNT_MAX = 8'hFF;

  // Interrupt request: any unmasked sticky status bit, gated by the global enable.
  function automatic logic irq_calc(input logic [DATA_W-1:0] ctrl_v,
                                    input logic [STS_W-1:0]  sts_v);
    return ctrl_v[CTRL_EN] & (|(sts_v & ctrl_v[CTRL_OVF_MSK:CTRL_EVT_MSK]));
  endfunction

endpackage

// File: rtl/i2c_regmap_if.sv
// Register access bus between the I2C slave (master side) and the register map (slave side).
interface i2c_regmap_if;
  import i2c_regmap_pkg::*;

  logic              i2c_wr_strobe;
  logic [ADDR_W-1:0] i2c_addr;
  logic [DATA_W-1:0] i2c_wdata;
  logic [DATA_W-1:0] i2c_rdata;

  modport master (
    output i2c_wr_strobe,
    output i2c_addr,
    output i2c_wdata,
    input  i2c_rdata
  );

  modport slave (
    input  i2c_wr_strobe,
    input  i2c_addr,
    input  i2c_wdata,
    output i2c_rdata
  );

endinterface

// File: rtl/i2c_regmap_cdc_pulse_sync.sv
// Level synchroniser plus rising-edge detect for a slow foreign-domain strobe.
// Flops reset to 1 so a strobe already high at reset release never produces a pulse.
module cdc_pulse_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign pulse_c = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/i2c_regmap.sv
// System-clock register map behind the I2C slave: CTRL, ID, sticky STATUS,
// saturating event counter and four GP output registers.
module i2c_regmap
  import i2c_regmap_pkg::*;
#(
  parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5,
  parameter int unsigned       SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  i2c_regmap_if.slave            bus,
  input  logic                   event_in,
  output logic [DATA_W-1:0]      ctrl,
  output logic [NUM_GP*DATA_W-1:0] gpo,
  output logic                   irq
);

  logic                           wr_pulse_c;
  logic [STS_W-1:0]               sts_q;
  logic [DATA_W-1:0]              evt_cnt_q;
  logic [NUM_GP-1:0][DATA_W-1:0]  gp_q;

  logic                           wr_ctrl_c;
  logic                           wr_sts_c;
  logic                           wr_cnt_c;
  logic                           wr_gp_c;
  logic [STS_W-1:0]               sts_set_c;
  logic [STS_W-1:0]               sts_clr_c;
  logic [STS_W-1:0]               sts_next_c;
  logic [DATA_W-1:0]              rd_mux_c;

  cdc_pulse_sync #(
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk     (clk),
    .rst     (rst),
    .d       (bus.i2c_wr_strobe),
    .pulse_c (wr_pulse_c)
  );

  // Address/data are sampled unsynchronised: they settled long before the pulse emerges.
  always_comb begin
    wr_ctrl_c = 1'b0;
    wr_sts_c  = 1'b0;
    wr_cnt_c  = 1'b0;
    wr_gp_c   = 1'b0;
    if (wr_pulse_c) begin
      wr_ctrl_c = (bus.i2c_addr == ADDR_CTRL);
      wr_sts_c  = (bus.i2c_addr == ADDR_STATUS);
      wr_cnt_c  = (bus.i2c_addr == ADDR_EVT_CNT);
      wr_gp_c   = (bus.i2c_addr[ADDR_W-1:2] == 6'd1);
    end
  end

  // Set wins over a simultaneous write-1-to-clear.
  always_comb begin
    sts_set_c          = '0;
    sts_set_c[STS_EVT] = event_in;
    sts_set_c[STS_OVF] = event_in && (evt_cnt_q == CNT_MAX);
    sts_clr_c          = wr_sts_c ? bus.i2c_wdata[STS_W-1:0] : '0;
    sts_next_c         = (sts_q & ~sts_clr_c) | sts_set_c;
  end

  always_comb begin
    rd_mux_c = '0;
    case (bus.i2c_addr)
      ADDR_CTRL:    rd_mux_c = ctrl;
      ADDR_ID:      rd_mux_c = ID_VALUE;
      ADDR_STATUS:  rd_mux_c = DATA_W'(sts_q);
      ADDR_EVT_CNT: rd_mux_c = evt_cnt_q;
      ADDR_GP0:     rd_mux_c = gp_q[0];
      ADDR_GP1:     rd_mux_c = gp_q[1];
      ADDR_GP2:     rd_mux_c = gp_q[2];
      ADDR_GP3:     rd_mux_c = gp_q[3];
      default:      rd_mux_c = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl          <= '0;
      gp_q          <= '0;
      sts_q         <= '0;
      evt_cnt_q     <= '0;
      irq           <= 1'b0;
      bus.i2c_rdata <= '0;
    end else begin
      if (wr_ctrl_c) ctrl <= bus.i2c_wdata;
      if (wr_gp_c)   gp_q[bus.i2c_addr[1:0]] <= bus.i2c_wdata;
      sts_q <= sts_next_c;
      // A clear together with an event leaves one counted event.
      if (wr_cnt_c)
        evt_cnt_q <= event_in ? DATA_W'(1) : '0;
      else if (event_in && (evt_cnt_q != CNT_MAX))
        evt_cnt_q <= evt_cnt_q + DATA_W'(1);
      irq           <= irq_calc(ctrl, sts_q);
      bus.i2c_rdata <= rd_mux_c;
    end
  end

  assign gpo = gp_q;

endmodule

// File: tb/tb_i2c_regmap.sv
// Directed plus randomized bench for i2c_regmap against a transaction-level register model.
module tb_i2c_regmap;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        event_in = 1'b0;
  logic [7:0]  ctrl;
  logic [31:0] gpo;
  logic        irq;

  i2c_regmap_if bus ();

  i2c_regmap #(.ID_VALUE(8'hA5), .SYNC_STAGES(SYNC)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .event_in (event_in),
    .ctrl     (ctrl),
    .gpo      (gpo),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Register model, updated per completed transaction.
  logic [7:0] m_ctrl;
  logic [1:0] m_sts;
  int         m_cnt;
  logic [7:0] m_gp [4];

  task automatic model_reset();
    m_ctrl = 8'h00;
    m_sts  = 2'b00;
    m_cnt  = 0;
    for (int i = 0; i < 4; i++) m_gp[i] = 8'h00;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h00) m_ctrl = d;
    else if (a == 8'h02) m_sts = m_sts & ~d[1:0];
    else if (a == 8'h03) m_cnt = 0;
    else if (a >= 8'h04 && a <= 8'h07) m_gp[a - 8'h04] = d;
  endtask

  task automatic model_events(input int n);
    if (n > 0) m_sts[0] = 1'b1;
    if (m_cnt + n > 255) m_sts[1] = 1'b1;
    m_cnt = (m_cnt + n > 255) ? 255 : m_cnt + n;
  endtask

  function automatic logic [7:0] model_read(input logic [7:0] a);
    case (a)
      8'h00: return m_ctrl;
      8'h01: return 8'hA5;
      8'h02: return {6'b0, m_sts};
      8'h03: return 8'(m_cnt);
      8'h04, 8'h05, 8'h06, 8'h07: return m_gp[a - 8'h04];
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic model_irq();
    logic hit;
    hit = (m_sts[0] && m_ctrl[1]) || (m_sts[1] && m_ctrl[2]);
    return hit && m_ctrl[0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.i2c_addr      = a;
    bus.i2c_wdata     = d;
    bus.i2c_wr_strobe = 1'b1;
    repeat (6) @(negedge clk);
    bus.i2c_wr_strobe = 1'b0;
    repeat (6) @(negedge clk);
    model_write(a, d);
  endtask

  task automatic events(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      event_in = 1'b1;
    end
    @(negedge clk);
    event_in = 1'b0;
    model_events(n);
  endtask

  task automatic rd_chk(input logic [7:0] a);
    @(negedge clk);
    bus.i2c_addr = a;
    @(negedge clk);
    @(negedge clk);
    check($sformatf("rd_%02h", a), 32'(bus.i2c_rdata), 32'(model_read(a)));
  endtask

  task automatic outs_chk(input string tag);
    @(negedge clk);
    check({tag, "_ctrl"}, 32'(ctrl), 32'(m_ctrl));
    check({tag, "_gpo"}, gpo, {m_gp[3], m_gp[2], m_gp[1], m_gp[0]});
    check({tag, "_irq"}, 32'(irq), 32'(model_irq()));
  endtask

  task automatic rd_all(input string tag);
    for (int i = 0; i < 8; i++) rd_chk(8'(i));
    outs_chk(tag);
  endtask

  initial begin
    int lat;
    int sel;
    logic [7:0] a;
    bus.i2c_wr_strobe = 1'b0;
    bus.i2c_addr      = 8'h00;
    bus.i2c_wdata     = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset defaults
    rd_all("rst");
    rd_chk(8'h37);

    // GP1 write: latency window and single commit under a long strobe
    @(negedge clk);
    bus.i2c_addr      = 8'h05;
    bus.i2c_wdata     = 8'h3C;
    bus.i2c_wr_strobe = 1'b1;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (gpo[15:8] == 8'h3C) break;
    end
    check("gp_lat_ok", 32'(lat >= SYNC + 1 && lat <= SYNC + 2), 32'd1);
    @(negedge clk);
    bus.i2c_wdata = 8'h99;
    repeat (40) @(negedge clk);
    bus.i2c_wr_strobe = 1'b0;
    repeat (6) @(negedge clk);
    m_gp[1] = 8'h3C;
    check("gp1_once", 32'(gpo[15:8]), 32'h3C);
    outs_chk("gp");

    // Events, irq and W1C
    wr(8'h00, 8'h07);
    events(3);
    rd_chk(8'h03);
    rd_chk(8'h02);
    outs_chk("evt");
    wr(8'h02, 8'h01);
    rd_chk(8'h02);
    outs_chk("w1c");

    // Saturation, then clear coinciding with event_in
    events(300);
    rd_chk(8'h03);
    rd_chk(8'h02);
    outs_chk("sat");
    @(negedge clk);
    bus.i2c_addr      = 8'h03;
    bus.i2c_wdata     = 8'($urandom);
    bus.i2c_wr_strobe = 1'b1;
    event_in          = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    event_in = 1'b0;
    repeat (6) @(negedge clk);
    bus.i2c_wr_strobe = 1'b0;
    repeat (6) @(negedge clk);
    m_cnt = 1;
    m_sts = 2'b11;
    rd_chk(8'h03);

    // Read-only and unmapped writes
    wr(8'h01, 8'h00);
    wr(8'h10, 8'hFF);
    rd_all("ro");
    rd_chk(8'h10);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          sel = int'($urandom_range(0, 9));
          a = (sel < 8) ? 8'(sel) : ((sel == 8) ? 8'h37 : 8'($urandom));
          wr(a, 8'($urandom));
        end
        1: events(($urandom_range(0, 9) == 0) ? 280 : int'($urandom_range(1, 20)));
        default: ;
      endcase
      sel = int'($urandom_range(0, 8));
      rd_chk((sel == 8) ? 8'h37 : 8'(sel));
      outs_chk("rnd");
    end

    // Reset released with strobe already high: no write
    @(negedge clk);
    rst               = 1'b1;
    bus.i2c_addr      = 8'h04;
    bus.i2c_wdata     = 8'h5A;
    bus.i2c_wr_strobe = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    bus.i2c_wr_strobe = 1'b0;
    repeat (6) @(negedge clk);
    rd_all("rst_hi");

    // Reset one clock after a strobe rise discards the write
    wr(8'h06, 8'hAB);
    wr(8'h00, 8'h05);
    @(negedge clk);
    bus.i2c_addr      = 8'h04;
    bus.i2c_wdata     = 8'hC3;
    bus.i2c_wr_strobe = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.i2c_wr_strobe = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    rd_all("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_regmap.md
Name: i2c_regmap

Overview:
- Register map directly downstream of the I2C slave. It consumes the slave's write strobe, register address and write data, and returns read data for the slave to shift out.
- Lives in the system clock domain (clk). It resynchronises the SCL-domain write strobe, commits writes to an 8-entry register bank, and exposes control/GPO outputs, an event counter and a sticky-status interrupt to the controller core.

Parameters:
- ID_VALUE, 8'hA5, constant returned by the read-only ID register (0x01).
- SYNC_STAGES, 2, flops in the write-strobe synchroniser; legal range ≥ 2.

Ports:
- clk  in  1  system clock; must be ≥ 4× the SCL frequency.
- rst  in  1  asynchronous, active-high reset.
- i2c_wr_strobe  in  1  write strobe from the I2C slave; SCL domain, high for exactly one SCL period.
- i2c_addr  in  8  register address from the slave; stable ≥ 8 SCL periods around each strobe.
- i2c_wdata  in  8  write data from the slave; changes on the same SCL edge the strobe rises.
- i2c_rdata  out  8  read data for the slave, registered in clk.
- event_in  in  1  clk-synchronous event; counted in every cycle it is high.
- ctrl  out  8  CTRL register contents.
- gpo  out  32  GP0..GP3 concatenated, GP0 in [7:0].
- irq  out  1  registered: |(STATUS[1:0] & CTRL[2:1]) & CTRL[0].

Behaviour:
- Reset values:
  - ctrl, gpo, STATUS, EVT_CNT, i2c_rdata, irq = 0.
  - All synchroniser flops and the edge-detect flop reset to 1. A strobe already high when rst deasserts therefore produces no write.
- Write commit:
  - The strobe passes through SYNC_STAGES flops, then a rising-edge detect produces a one-clk wr_pulse.
  - On wr_pulse, i2c_addr and i2c_wdata are sampled directly; they are stable because they settled ≥ SYNC_STAGES clk earlier.
  - The register updates at the clk edge after wr_pulse. Latency from the strobe rising edge to the register update is SYNC_STAGES+1 to SYNC_STAGES+2 clk.
  - Exactly one commit per strobe pulse, however long the strobe stays high.
- Register map:
  - 0x00 CTRL, RW.
    - bit0: global irq enable.
    - bit1: event irq mask.
    - bit2: overflow irq mask.
    - bits 7:3: RW scratch.
  - 0x01 ID, RO, returns ID_VALUE. Writes are ignored.
  - 0x02 STATUS, write-1-to-clear, bits 7:2 read 0.
    - bit0 EVT: set when event_in is high.
    - bit1 OVF: set when event_in is high while EVT_CNT == 8'hFF.
  - 0x03 EVT_CNT, RO counter.
    - +1 each clk in which event_in is high.
    - Saturates at 8'hFF.
    - Any write clears it regardless of data.
  - 0x04..0x07 GP0..GP3, RW.
  - 0x08..0xFF unmapped: read 8'h00, writes ignored.
- Simultaneous events:
  - STATUS: a set and a W1C of the same bit in the same cycle leave the bit set (set wins).
  - EVT_CNT: a clear and event_in in the same cycle give EVT_CNT = 1.
  - EVT_CNT saturated at 8'hFF with event_in high: stays 8'hFF and OVF is set.
- Read path:
  - i2c_rdata <= mux(i2c_addr) every clk, with no synchronisation of i2c_addr.
  - The slave samples read data ≥ 1 SCL period after the address commits, so the registered value has settled.
- irq: registered, so it asserts 1 clk after the STATUS bit sets and deasserts 1 clk after the clear.
- Reset mid-operation: all state returns to reset values immediately. A write in flight in the synchroniser is discarded.

Decomposition:
- Shared package i2c_regmap_pkg holds:
  - address constants ADDR_CTRL, ADDR_ID, ADDR_STATUS, ADDR_EVT_CNT, ADDR_GP0..ADDR_GP3;
  - bit-index constants CTRL_EN, CTRL_EVT_MSK, CTRL_OVF_MSK, STS_EVT, STS_OVF.
- One sub-module, cdc_pulse_sync: a parameterised SYNC_STAGES level synchroniser plus rising-edge detect, with reset value 1. It is reusable for other SCL-domain strobes.

Test Plan:
- Reset defaults: assert rst, release with strobe low, read all addresses → CTRL/STATUS/EVT_CNT/GP = 8'h00, ID = 8'hA5, 8'h37 = 8'h00, irq = 0.
- GP write: pulse strobe (addr 8'h05, data 8'h3C), hold high 40 clk → exactly one commit; gpo[15:8] = 8'h3C; commit lands SYNC_STAGES+1..+2 clk after the strobe rises.
- Event and W1C:
  - Set CTRL = 8'h07, drive event_in for 3 clk → EVT_CNT = 3, STATUS = 8'h01, irq = 1 one clk later.
  - Write STATUS = 8'h01 → STATUS = 0, irq = 0.
- Saturation: drive event_in for 300 clk → EVT_CNT = 8'hFF, STATUS = 8'h03. A clear coinciding with event_in → EVT_CNT = 1.
- Read-only and unmapped: write 8'h00 to ID and 8'hFF to 8'h10 → ID still 8'hA5, no other register changes, 8'h10 reads 8'h00.
- Reset robustness:
  - Release rst with strobe held high → no write.
  - Assert rst 1 clk after a strobe rising edge → write discarded, registers at reset values.
